// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller: opcodes, FSM states, result entry.
package alu_pkg;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SSUB = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // One captured ALU result; packs to {op, ovf, cout, f} = 9 bits.
    typedef struct packed {
        logic [1:0] op;
        logic       ovf;
        logic       cout;
        logic [4:0] f;
    } res_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Result FIFO: power-of-two depth, pointers wrap naturally, head masked to 0 when empty.
module alu_res_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  res_t                     push_data,
    input  logic                     pop,
    output res_t                     head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    res_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop on an empty FIFO is ignored; a push into a full one is dropped defensively.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != DEPTH_C);

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; not reset because the head is masked until an entry is written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_valid = (count != '0);
    assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to an external combinational ALU and queues its results.
//
// state | meaning
// IDLE  | ready for a request when the result FIFO has room
// EXEC  | operands held on alu_*; result captured into the FIFO at the closing edge
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_x,
    input  logic [4:0]               in_y,
    input  logic [1:0]               in_s,
    output logic [4:0]               alu_x,
    output logic [4:0]               alu_y,
    output logic [1:0]               alu_s,
    input  logic [4:0]               alu_f,
    input  logic                     alu_cout,
    input  logic                     alu_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_f,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic [1:0]               out_op,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sticky_ovf,
    input  logic                     clr_sticky
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   push;
    res_t   push_data;
    res_t   head;

    assign accept = in_valid && in_ready;

    // State register; reset drops any in-flight operation so nothing is pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: accept moves to EXEC, EXEC always returns after one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State outputs: ready only in IDLE with FIFO space, push at the end of EXEC.
    always_comb begin
        in_ready = 1'b0;
        push     = 1'b0;
        case (state)
            IDLE:    in_ready = (count < DEPTH_C);
            EXEC:    push = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Operand registers only change on accept so the ALU inputs stay quiet otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_x <= '0;
            alu_y <= '0;
            alu_s <= OP_MULT;
        end else if (accept) begin
            alu_x <= in_x;
            alu_y <= in_y;
            alu_s <= in_s;
        end
    end

    // Sticky overflow; a clear at the same edge as an overflow push wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    sticky_ovf <= 1'b0;
        else if (clr_sticky)        sticky_ovf <= 1'b0;
        else if (push && alu_ovf)   sticky_ovf <= 1'b1;
    end

    assign push_data = '{op: alu_s, ovf: alu_ovf, cout: alu_cout, f: alu_f};

    alu_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .pop        (out_ready),
        .head       (head),
        .head_valid (out_valid),
        .count      (count)
    );

    assign out_f    = head.f;
    assign out_cout = head.cout;
    assign out_ovf  = head.ovf;
    assign out_op   = head.op;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a scoreboard queue and an independent monitor.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [4:0] in_x, in_y;
    logic [1:0] in_s;
    logic [4:0] alu_x, alu_y;
    logic [1:0] alu_s;
    logic [4:0] alu_f;
    logic       alu_cout, alu_ovf;
    logic       out_valid, out_ready;
    logic [4:0] out_f;
    logic       out_cout, out_ovf;
    logic [1:0] out_op;
    logic [2:0] count;
    logic       sticky_ovf, clr_sticky;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] sbq[$];

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_s(in_s),
        .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_cout(out_cout), .out_ovf(out_ovf), .out_op(out_op),
        .count(count), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    // The team's 5-bit ALU: mult keeps product[5:1], compare flags x<y,
    // add gives carry and signed overflow, shifted subtract gives (x-y)<<1 with borrow.
    logic [9:0] prod;
    logic [5:0] sum, diff;
    always_comb begin
        prod     = {5'b0, alu_x} * {5'b0, alu_y};
        sum      = {1'b0, alu_x} + {1'b0, alu_y};
        diff     = {1'b0, alu_x} - {1'b0, alu_y};
        alu_f    = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (alu_s)
            OP_MULT: begin alu_f = prod[5:1]; alu_ovf = |prod[9:6]; end
            OP_CMP:  alu_cout = (alu_x < alu_y);
            OP_ADD:  begin
                alu_f    = sum[4:0];
                alu_cout = sum[5];
                alu_ovf  = (alu_x[4] == alu_y[4]) && (sum[4] != alu_x[4]);
            end
            default: begin alu_f = {diff[3:0], 1'b0}; alu_cout = diff[5]; end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Drive one request, hold it until accepted, record the hand-computed result.
    task automatic send(input logic [4:0] x, input logic [4:0] y, input logic [1:0] s,
                        input logic [4:0] ef, input logic ec, input logic eo);
        int cyc = 0;
        in_x = x; in_y = y; in_s = s; in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            cyc++;
            if (cyc > 200) begin
                timeout("accept_wait");
                in_valid = 1'b0;
                return;
            end
        end
        sbq.push_back({s, eo, ec, ef});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_count(input logic [2:0] v, input int budget);
        int c = 0;
        while (count !== v) begin
            @(posedge clk); #1;
            c++;
            if (c > budget) begin
                timeout("count_wait");
                return;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every head that is popped must match the oldest expected entry.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    timeout("unexpected_entry");
                end else begin
                    e = sbq.pop_front();
                    chk("entry", {23'b0, out_op, out_ovf, out_cout, out_f}, {23'b0, e});
                end
            end else if (!out_valid) begin
                chk("idle_fields_zero", {23'b0, out_op, out_ovf, out_cout, out_f}, 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_s = '0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_xy", {alu_x, alu_y}, 0);
        chk("rst_alu_s", alu_s, 0);
        chk("rst_sticky", sticky_ovf, 0);
        cycles(2);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", in_ready, 1);

        // Overflowing add: latency, fields, sticky, operand hold.
        send(5'b01111, 5'b00001, OP_ADD, 5'b10000, 1'b0, 1'b1);
        chk("accept_edge_valid", out_valid, 0);
        chk("accept_alu_x", alu_x, 5'b01111);
        chk("exec_not_ready", in_ready, 0);
        in_x = 5'b11111;
        cycles(2);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_f", out_f, 5'b10000);
        chk("lat_out_cout", out_cout, 0);
        chk("lat_out_ovf", out_ovf, 1);
        chk("lat_sticky", sticky_ovf, 1);
        chk("lat_count", count, 1);
        chk("alu_x_hold", alu_x, 5'b01111);
        clr_sticky = 1'b1;
        cycles(1);
        clr_sticky = 1'b0;
        chk("sticky_cleared", sticky_ovf, 0);
        out_ready = 1'b1;
        wait_count(0, 20);

        // Each opcode with the consumer always ready.
        send(5'b01110, 5'b00011, OP_MULT, 5'b10101, 1'b0, 1'b0);
        send(5'b00101, 5'b01001, OP_CMP,  5'b00000, 1'b1, 1'b0);
        send(5'b01001, 5'b00011, OP_SSUB, 5'b01100, 1'b0, 1'b0);
        send(5'b11111, 5'b00010, OP_ADD,  5'b00001, 1'b1, 1'b0);
        cycles(3);
        wait_count(0, 20);
        chk("no_sticky_from_clean_ops", sticky_ovf, 0);

        // Five back-to-back requests into a stalled consumer.
        out_ready = 1'b0;
        fork
            begin
                send(5'd1, 5'd2, OP_ADD, 5'd3,  1'b0, 1'b0);
                send(5'd3, 5'd4, OP_ADD, 5'd7,  1'b0, 1'b0);
                send(5'd5, 5'd6, OP_ADD, 5'd11, 1'b0, 1'b0);
                send(5'd7, 5'd8, OP_ADD, 5'd15, 1'b0, 1'b0);
                send(5'd9, 5'd1, OP_ADD, 5'd10, 1'b0, 1'b0);
            end
            begin
                wait_count(4, 50);
                chk("full_not_ready", in_ready, 0);
                cycles(3);
                chk("full_count_held", count, 4);
                chk("full_still_not_ready", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        wait_count(0, 30);
        chk("b2b_all_drained", sbq.size(), 0);

        // Push and pop on the same edge with two entries queued.
        out_ready = 1'b0;
        send(5'd2, 5'd3, OP_ADD, 5'd5, 1'b0, 1'b0);
        send(5'd4, 5'd4, OP_ADD, 5'd8, 1'b0, 1'b0);
        wait_count(2, 10);
        send(5'd6, 5'd1, OP_ADD, 5'd7, 1'b0, 1'b0);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        chk("pushpop_count", count, 2);
        chk("pushpop_head", out_f, 5'd8);
        out_ready = 1'b1;
        wait_count(0, 20);

        // Reset in the middle of EXEC.
        out_ready = 1'b0;
        send(5'd1, 5'd1, OP_ADD, 5'd2, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_alu_x", alu_x, 0);
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", in_ready, 1);
        cycles(2);
        chk("midrst_no_entry", count, 0);

        // Clear coinciding with an overflow push.
        send(5'b01111, 5'b00001, OP_ADD, 5'b10000, 1'b0, 1'b1);
        clr_sticky = 1'b1;
        cycles(1);
        clr_sticky = 1'b0;
        chk("clr_wins_sticky", sticky_ovf, 0);
        chk("clr_entry_count", count, 1);
        chk("clr_entry_ovf", out_ovf, 1);
        out_ready = 1'b1;
        wait_count(0, 20);
        cycles(2);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
